bless_router_param: RTL and testbench
=====================================

# bless_router_param

Parametrised bufferless deflection (BLESS) router tile for the 2D mesh NoC. It has four mesh ports (W, E, S, N), an ejection port, and an injection port fed by an internal FIFO with valid/ready backpressure. Arbitration is oldest-first by age with dimension-ordered preferred routing. It adds per-hop age tracking and a saturating deflection counter for the performance monitors.

## Interface
Parameters:
- FLIT_W, 64 — total flit width: {age, xdst, ydst, payload}, MSB first.
- AGE_W, 8 — age field width, bits [FLIT_W-1 -: AGE_W].
- COORD_W, 3 — width of each of xdst and ydst, placed directly below age (xdst above ydst).
- MY_X, 0 / MY_Y, 0 — this router's mesh coordinates.
- INJ_DEPTH, 4 — injection FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-low.
- dinW, dinE, dinS, dinN  in  FLIT_W  — flits from neighbours; all-zero = no flit.
- inj_data  in  FLIT_W  — local injection flit; the age field is ignored.
- inj_valid  in  1  — injection request.
- inj_ready  out  1  — FIFO not full; a push happens when inj_valid & inj_ready.
- doutW, doutE, doutS, doutN  out  FLIT_W  — flits to neighbours, registered; zero = idle.
- doutLocal  out  FLIT_W  — ejected flit, registered; zero = idle.
- deflect_cnt  out  16  — saturating count of deflected flits.

## Operation
- Stage 1: register each din. A flit is valid iff its register is non-zero.
- Route compute per valid flit, with East = x+1 and North = y+1:
  - productive X port: E if xdst>MY_X, W if xdst<MY_X;
  - productive Y port: N if ydst>MY_Y, S if ydst<MY_Y;
  - local if xdst==MY_X and ydst==MY_Y.
- Priority order: larger age first; on equal age, lower input index wins (W=0, E=1, S=2, N=3).
- Ejection: the highest-priority local-destined flit takes doutLocal. At most one ejection per cycle.
- Allocation, done in priority order over the remaining network flits. Each flit takes:
  1. its free productive X port; else
  2. its free productive Y port; else
  3. the first free port in order W, E, S, N.
- Deflection: a flit that receives no productive port is deflected. This includes local-destined flits that lose ejection. Every network flit always gets an output port (4 inputs, 4 outputs).
- Injection:
  - If the FIFO is non-empty and at least one output port is still free after allocation, the FIFO head is popped and placed on the first free port.
  - It prefers its productive X port, then Y, then W, E, S, N.
  - Its age is forced to 0 before the output increment.
  - A head whose non-age bits are all zero is popped and discarded.
  - A head destined to MY_X/MY_Y is popped and discarded; local traffic never enters the mesh.
- Age: every flit written to a mesh output gets age+1, saturating at 2^AGE_W−1. The ejected flit keeps its age unchanged.
- deflect_cnt increments each cycle by the number of deflected flits (0–4) and saturates at 16'hFFFF.
- FIFO: circular buffer of INJ_DEPTH entries with an occupancy counter; inj_ready = (count != INJ_DEPTH).
  - A push and a pop in the same cycle leave the count unchanged.
  - A push lands in a slot; the head is readable from the next cycle.

## Timing
- Reset (async assert): all dout*, doutLocal, deflect_cnt = 0; FIFO empty; inj_ready = 1; input registers cleared. In-flight flits are dropped.
- Mesh latency: a flit present on din at edge k is sampled at k and appears on dout after edge k+1 (2 cycles).
- Injection latency: a flit pushed at edge k can win a free port in cycle k→k+1 and appear on dout after edge k+1.
- The FIFO never overflows. A push while full is impossible because inj_ready=0, and data is held by the source.
- A pop when empty does not occur; injection is gated by non-empty.

## Test plan
Setup for all scenarios: MY_X=1, MY_Y=1, COORD_W=3, AGE_W=8.
1. Straight routing: dinW = {age 5, x3, y1, payload 0xA} → after 2 edges doutE carries age 6, same other fields; deflect_cnt stays 0.
2. Ejection contention: dinW (age 3) and dinN (age 9) both to (1,1) → doutLocal = N flit (age 9). W flit is deflected to the first free port with age 4; deflect_cnt = 1.
3. Equal-age conflict: dinW and dinS both age 2, both to (3,1) → W flit gets doutE. S flit is deflected to doutW (first free in W, E, S, N order); deflect_cnt +1.
4. Injection with full mesh: all four din carry flits every cycle while inj_valid=1.
   - Required: FIFO fills to 4, inj_ready drops to 0, nothing is injected.
   - Then drop dinN: the FIFO head appears on dout with age 1 two edges later, and inj_ready returns to 1 one edge after the pop.
5. Saturation: flit with age 255 → output age 255. Force 70000 deflections → deflect_cnt holds 0xFFFF.
6. Mid-traffic reset: assert reset with the FIFO holding 3 flits and outputs busy → all outputs 0 and inj_ready=1 immediately. After release, no stale flit ever appears.

Source files
------------

// File: rtl/bless_router_param.sv
// Bufferless deflection router tile: oldest-first allocation with dimension-ordered
// preferred ports, one ejection per cycle, and a FIFO-fed injection port.
module bless_router_param #(
   parameter int FLIT_W    = 64,
   parameter int AGE_W     = 8,
   parameter int COORD_W   = 3,
   parameter int MY_X      = 0,
   parameter int MY_Y      = 0,
   parameter int INJ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] dinW,
   input  logic [FLIT_W-1:0] dinE,
   input  logic [FLIT_W-1:0] dinS,
   input  logic [FLIT_W-1:0] dinN,
   input  logic [FLIT_W-1:0] inj_data,
   input  logic              inj_valid,
   output logic              inj_ready,
   output logic [FLIT_W-1:0] doutW,
   output logic [FLIT_W-1:0] doutE,
   output logic [FLIT_W-1:0] doutS,
   output logic [FLIT_W-1:0] doutN,
   output logic [FLIT_W-1:0] doutLocal,
   output logic [15:0]       deflect_cnt
);

   localparam int PTR_W = $clog2(INJ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int X_LSB = FLIT_W - AGE_W - COORD_W;
   localparam int Y_LSB = X_LSB - COORD_W;
   localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
   localparam logic [COORD_W-1:0] MY = COORD_W'(MY_Y);
   localparam logic [CNT_W-1:0]   FULL = CNT_W'(INJ_DEPTH);
   localparam logic [AGE_W-1:0]   AGE_MAX = '1;
   localparam logic [1:0] P_W = 2'd0, P_E = 2'd1, P_S = 2'd2, P_N = 2'd3;

   logic [FLIT_W-1:0] din_q [4];
   logic [FLIT_W-1:0] out_n [4];
   logic [FLIT_W-1:0] local_n;
   logic [FLIT_W-1:0] mem [INJ_DEPTH];
   logic [FLIT_W-1:0] head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [6:0]        rt [4];
   logic [6:0]        head_rt;
   logic [1:0]        rank [4];
   logic [3:0]        valid, done, free;
   logic [2:0]        defl, sel;
   logic              ejected, push, pop;
   logic [16:0]       cnt_sum;

   function automatic logic [AGE_W-1:0] age_of(input logic [FLIT_W-1:0] f);
      return f[FLIT_W-1 -: AGE_W];
   endfunction

   function automatic logic [FLIT_W-1:0] inc_age(input logic [FLIT_W-1:0] f);
      logic [FLIT_W-1:0] r;
      r = f;
      if (age_of(f) != AGE_MAX) r[FLIT_W-1 -: AGE_W] = age_of(f) + 1'b1;
      return r;
   endfunction

   // {is_local, has_x, x_port[1:0], has_y, y_port[1:0]}
   function automatic logic [6:0] route(input logic [FLIT_W-1:0] f);
      logic [COORD_W-1:0] x, y;
      logic [6:0] r;
      x = f[X_LSB +: COORD_W];
      y = f[Y_LSB +: COORD_W];
      r = '0;
      r[6] = (x == MX) && (y == MY);
      if (x > MX) r[5:3] = {1'b1, P_E};
      else if (x < MX) r[5:3] = {1'b1, P_W};
      if (y > MY) r[2:0] = {1'b1, P_N};
      else if (y < MY) r[2:0] = {1'b1, P_S};
      return r;
   endfunction

   // {productive, port}: productive X, then Y, then lowest-index free port
   function automatic logic [2:0] pick(input logic [6:0] r, input logic [3:0] fr);
      logic [1:0] p;
      p = '0;
      if (r[5] && fr[r[4:3]]) return {1'b1, r[4:3]};
      if (r[2] && fr[r[1:0]]) return {1'b1, r[1:0]};
      for (int k = 3; k >= 0; k--) if (fr[k]) p = 2'(k);
      return {1'b0, p};
   endfunction

   // inj_valid/inj_ready: a push happens on an edge where both are high; the
   // source holds inj_data stable while inj_ready is low.
   assign inj_ready = (count != FULL);
   assign push      = inj_valid && inj_ready;
   assign head      = mem[rd_ptr];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         valid[i] = |din_q[i];
         rt[i]    = route(din_q[i]);
         rank[i]  = '0;
         done[i]  = 1'b0;
         out_n[i] = '0;
      end
      head_rt = route(head);
      local_n = '0;
      free    = 4'hF;
      defl    = '0;
      sel     = '0;
      ejected = 1'b0;
      pop     = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (j != i && valid[j] &&
                (!valid[i] || age_of(din_q[j]) > age_of(din_q[i]) ||
                 (age_of(din_q[j]) == age_of(din_q[i]) && j < i)))
               rank[i] = rank[i] + 2'd1;
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 4; i++)
            if (valid[i] && rank[i] == 2'(p) && rt[i][6] && !ejected) begin
               local_n = din_q[i];
               ejected = 1'b1;
               done[i] = 1'b1;
            end
      // Remaining flits always find a port: at most four contend for four outputs.
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 4; i++)
            if (valid[i] && !done[i] && rank[i] == 2'(p)) begin
               sel = pick(rt[i], free);
               free[sel[1:0]] = 1'b0;
               out_n[sel[1:0]] = inc_age(din_q[i]);
               if (!sel[2]) defl = defl + 3'd1;
            end
      if (count != '0 && |free) begin
         pop = 1'b1;
         if (|head[FLIT_W-AGE_W-1:0] && !head_rt[6]) begin
            sel = pick(head_rt, free);
            out_n[sel[1:0]] = inc_age({{AGE_W{1'b0}}, head[FLIT_W-AGE_W-1:0]});
         end
      end
   end

   assign cnt_sum = {1'b0, deflect_cnt} + 17'(defl);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) din_q[i] <= '0;
         doutW       <= '0;
         doutE       <= '0;
         doutS       <= '0;
         doutN       <= '0;
         doutLocal   <= '0;
         deflect_cnt <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else begin
         din_q[0]    <= dinW;
         din_q[1]    <= dinE;
         din_q[2]    <= dinS;
         din_q[3]    <= dinN;
         doutW       <= out_n[0];
         doutE       <= out_n[1];
         doutS       <= out_n[2];
         doutN       <= out_n[3];
         doutLocal   <= local_n;
         deflect_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= inj_data;
   end

endmodule

// File: tb/tb_bless_router_param.sv
// Directed bench for bless_router_param at mesh position (1,1).
module tb_bless_router_param;

   logic        clk;
   logic        reset;
   logic [63:0] dinW, dinE, dinS, dinN, inj_data;
   logic        inj_valid, inj_ready;
   logic [63:0] doutW, doutE, doutS, doutN, doutLocal;
   logic [15:0] deflect_cnt;
   int          n_cmp = 0;
   int          n_err = 0;

   bless_router_param #(
      .FLIT_W(64), .AGE_W(8), .COORD_W(3), .MY_X(1), .MY_Y(1), .INJ_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .dinW(dinW), .dinE(dinE), .dinS(dinS), .dinN(dinN),
      .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
      .doutW(doutW), .doutE(doutE), .doutS(doutS), .doutN(doutN),
      .doutLocal(doutLocal), .deflect_cnt(deflect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk(input logic [7:0] a, input logic [2:0] x,
                                      input logic [2:0] y, input logic [49:0] p);
      return {a, x, y, p};
   endfunction

   task automatic clear_inputs();
      dinW = '0; dinE = '0; dinS = '0; dinN = '0;
      inj_data = '0; inj_valid = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      #3;
      n_cmp++;
      if ((doutW | doutE | doutS | doutN | doutLocal) !== 64'd0) begin
         n_err++; $display("FAIL reset_outs: got %h/%h/%h/%h/%h required all 0",
                           doutW, doutE, doutS, doutN, doutLocal);
      end
      n_cmp++;
      if (inj_ready !== 1'b1 || deflect_cnt !== 16'd0) begin
         n_err++; $display("FAIL reset_state: got ready=%b cnt=%h required ready=1 cnt=0",
                           inj_ready, deflect_cnt);
      end
      do_reset();
   endtask

   task automatic test_straight();
      do_reset();
      dinW = mk(8'd5, 3'd3, 3'd1, 50'hA);
      step();
      dinW = '0;
      step();
      n_cmp++;
      if (doutE !== mk(8'd6, 3'd3, 3'd1, 50'hA)) begin
         n_err++; $display("FAIL straight_doutE: got %h required %h", doutE, mk(8'd6, 3'd3, 3'd1, 50'hA));
      end
      n_cmp++;
      if ((doutW | doutS | doutN | doutLocal) !== 64'd0 || deflect_cnt !== 16'd0) begin
         n_err++; $display("FAIL straight_others: got W%h S%h N%h L%h cnt %h required all 0",
                           doutW, doutS, doutN, doutLocal, deflect_cnt);
      end
      step();
      n_cmp++;
      if (doutE !== 64'd0) begin
         n_err++; $display("FAIL straight_idle: got %h required 0", doutE);
      end
   endtask

   task automatic test_eject_contention();
      do_reset();
      dinW = mk(8'd3, 3'd1, 3'd1, 50'hB0);
      dinN = mk(8'd9, 3'd1, 3'd1, 50'hB1);
      step();
      clear_inputs();
      step();
      n_cmp++;
      if (doutLocal !== mk(8'd9, 3'd1, 3'd1, 50'hB1)) begin
         n_err++; $display("FAIL eject_local: got %h required %h", doutLocal, mk(8'd9, 3'd1, 3'd1, 50'hB1));
      end
      n_cmp++;
      if (doutW !== mk(8'd4, 3'd1, 3'd1, 50'hB0)) begin
         n_err++; $display("FAIL eject_deflect_W: got %h required %h", doutW, mk(8'd4, 3'd1, 3'd1, 50'hB0));
      end
      n_cmp++;
      if (deflect_cnt !== 16'd1) begin
         n_err++; $display("FAIL eject_cnt: got %0d required 1", deflect_cnt);
      end
   endtask

   task automatic test_equal_age();
      do_reset();
      dinW = mk(8'd2, 3'd3, 3'd1, 50'hC0);
      dinS = mk(8'd2, 3'd3, 3'd1, 50'hC1);
      step();
      clear_inputs();
      step();
      n_cmp++;
      if (doutE !== mk(8'd3, 3'd3, 3'd1, 50'hC0)) begin
         n_err++; $display("FAIL equal_age_E: got %h required %h", doutE, mk(8'd3, 3'd3, 3'd1, 50'hC0));
      end
      n_cmp++;
      if (doutW !== mk(8'd3, 3'd3, 3'd1, 50'hC1)) begin
         n_err++; $display("FAIL equal_age_W: got %h required %h", doutW, mk(8'd3, 3'd3, 3'd1, 50'hC1));
      end
      n_cmp++;
      if (deflect_cnt !== 16'd1) begin
         n_err++; $display("FAIL equal_age_cnt: got %0d required 1", deflect_cnt);
      end
   endtask

   task automatic test_injection_full_mesh();
      do_reset();
      dinW = mk(8'd1, 3'd3, 3'd1, 50'h11);
      dinE = mk(8'd1, 3'd0, 3'd1, 50'h22);
      dinS = mk(8'd1, 3'd1, 3'd3, 50'h33);
      dinN = mk(8'd1, 3'd1, 3'd0, 50'h44);
      inj_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         inj_data = mk(8'hAB, 3'd3, 3'd1, 50'(k));
         step();
      end
      n_cmp++;
      if (inj_ready !== 1'b0) begin
         n_err++; $display("FAIL inj_full_ready: got %b required 0", inj_ready);
      end
      inj_valid = 1'b0;
      step();
      step();
      n_cmp++;
      if (doutS !== mk(8'd2, 3'd1, 3'd0, 50'h44) || doutE !== mk(8'd2, 3'd3, 3'd1, 50'h11)) begin
         n_err++; $display("FAIL inj_blocked: got S%h E%h required S%h E%h", doutS, doutE,
                           mk(8'd2, 3'd1, 3'd0, 50'h44), mk(8'd2, 3'd3, 3'd1, 50'h11));
      end
      dinN = '0;
      step();
      n_cmp++;
      if (doutS !== mk(8'd2, 3'd1, 3'd0, 50'h44) || inj_ready !== 1'b0) begin
         n_err++; $display("FAIL inj_drop_edge1: got S%h ready %b required S%h ready 0",
                           doutS, inj_ready, mk(8'd2, 3'd1, 3'd0, 50'h44));
      end
      step();
      n_cmp++;
      if (doutS !== mk(8'd1, 3'd3, 3'd1, 50'd1)) begin
         n_err++; $display("FAIL inj_head_out: got %h required %h", doutS, mk(8'd1, 3'd3, 3'd1, 50'd1));
      end
      n_cmp++;
      if (inj_ready !== 1'b1 || doutN !== mk(8'd2, 3'd1, 3'd3, 50'h33)) begin
         n_err++; $display("FAIL inj_after_pop: got ready %b N%h required ready 1 N%h",
                           inj_ready, doutN, mk(8'd2, 3'd1, 3'd3, 50'h33));
      end
      step();
      n_cmp++;
      if (doutS !== mk(8'd1, 3'd3, 3'd1, 50'd2)) begin
         n_err++; $display("FAIL inj_second: got %h required %h", doutS, mk(8'd1, 3'd3, 3'd1, 50'd2));
      end
      n_cmp++;
      if (deflect_cnt !== 16'd0) begin
         n_err++; $display("FAIL inj_cnt: got %0d required 0", deflect_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      dinW = mk(8'd255, 3'd3, 3'd1, 50'hD0);
      step();
      dinW = '0;
      step();
      n_cmp++;
      if (doutE !== mk(8'd255, 3'd3, 3'd1, 50'hD0)) begin
         n_err++; $display("FAIL age_sat: got %h required %h", doutE, mk(8'd255, 3'd3, 3'd1, 50'hD0));
      end
      dinW = mk(8'd0, 3'd3, 3'd1, 50'd1);
      dinE = mk(8'd0, 3'd3, 3'd1, 50'd2);
      dinS = mk(8'd0, 3'd3, 3'd1, 50'd3);
      dinN = mk(8'd0, 3'd3, 3'd1, 50'd4);
      step();
      clear_inputs();
      step();
      n_cmp++;
      if (deflect_cnt !== 16'd3 || doutW !== mk(8'd1, 3'd3, 3'd1, 50'd2)) begin
         n_err++; $display("FAIL defl_three: got cnt %0d W%h required cnt 3 W%h",
                           deflect_cnt, doutW, mk(8'd1, 3'd3, 3'd1, 50'd2));
      end
      dinW = mk(8'd0, 3'd3, 3'd1, 50'd1);
      dinE = mk(8'd0, 3'd3, 3'd1, 50'd2);
      dinS = mk(8'd0, 3'd3, 3'd1, 50'd3);
      dinN = mk(8'd0, 3'd3, 3'd1, 50'd4);
      repeat (23400) @(posedge clk);
      #1;
      n_cmp++;
      if (deflect_cnt !== 16'hFFFF) begin
         n_err++; $display("FAIL defl_sat: got %h required ffff", deflect_cnt);
      end
      repeat (5) step();
      n_cmp++;
      if (deflect_cnt !== 16'hFFFF) begin
         n_err++; $display("FAIL defl_sat_hold: got %h required ffff", deflect_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_mid_traffic_reset();
      do_reset();
      dinW = mk(8'd1, 3'd3, 3'd1, 50'h11);
      dinE = mk(8'd1, 3'd0, 3'd1, 50'h22);
      dinS = mk(8'd1, 3'd1, 3'd3, 50'h33);
      dinN = mk(8'd1, 3'd1, 3'd0, 50'h44);
      inj_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         inj_data = mk(8'd0, 3'd3, 3'd1, 50'(16 + k));
         step();
      end
      inj_valid = 1'b0;
      step();
      n_cmp++;
      if (doutE !== mk(8'd2, 3'd3, 3'd1, 50'h11)) begin
         n_err++; $display("FAIL mid_busy: got %h required %h", doutE, mk(8'd2, 3'd3, 3'd1, 50'h11));
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ((doutW | doutE | doutS | doutN | doutLocal) !== 64'd0 || inj_ready !== 1'b1) begin
         n_err++; $display("FAIL mid_reset_async: got W%h E%h S%h N%h L%h ready %b required 0 and ready 1",
                           doutW, doutE, doutS, doutN, doutLocal, inj_ready);
      end
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         n_cmp++;
         if ((doutW | doutE | doutS | doutN | doutLocal) !== 64'd0) begin
            n_err++; $display("FAIL mid_stale_%0d: got W%h E%h S%h N%h L%h required all 0",
                              c, doutW, doutE, doutS, doutN, doutLocal);
         end
      end
      n_cmp++;
      if (deflect_cnt !== 16'd0 || inj_ready !== 1'b1) begin
         n_err++; $display("FAIL mid_final: got cnt %0d ready %b required 0 and 1", deflect_cnt, inj_ready);
      end
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      test_reset();
      test_straight();
      test_eject_contention();
      test_equal_age();
      test_injection_full_mesh();
      test_saturation();
      test_mid_traffic_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
